return_addr_stack: RTL
======================

Name: return_addr_stack

Overview:
- Parametrised successor to the single-entry return register (RR) in the pipelined datapath: a DEPTH-entry LIFO of return addresses, so calls, jumps-with-return and for-loop back-targets can nest.
- Sits beside the PC fetch logic. Decode pushes pc+1 (or pc for loop-type instructions) on call; the return/loop path pops and drives the PC mux.
- Honours the pipeline's stall and flush controls.
- Provides sticky overflow/underflow status and a selectable full-stack policy.

Parameters:
- DATA_W, 16, width of one stored address.
- DEPTH, 8, number of entries; must be a power of two, minimum 2.
- OVERWRITE, 1, full-stack policy: 1 = a push when full overwrites the oldest entry; 0 = a push when full is dropped.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- push  input  1  push push_data this cycle.
- pop  input  1  pop the top entry this cycle.
- push_data  input  DATA_W  address to push.
- stall  input  1  hold all state; push and pop are ignored.
- flush  input  1  discard all entries (pipeline flush or context reset).
- clr_err  input  1  clear the sticky error flags.
- top  output  DATA_W  current top-of-stack; 0 when empty.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- count  output  $clog2(DEPTH+1)  number of valid entries.
- overflow  output  1  sticky: a push arrived while full.
- underflow  output  1  sticky: a pop arrived while empty.

Behaviour:
- Storage: mem[0..DEPTH-1], write pointer sp of width $clog2(DEPTH), count register. Pointer arithmetic wraps modulo DEPTH.
- top = mem[sp-1] combinationally when count > 0, else 0. Status outputs are decoded from registers, so there are no extra latency stages.
- A push takes effect on the next rising edge; top reflects it in that cycle.
- Reset (asynchronous): sp = 0, count = 0, overflow = 0, underflow = 0. Memory need not reset, because top is forced to 0 while empty. Reset mid-operation abandons all entries.
- Priority per edge: flush > stall > push/pop.
- flush = 1: sp = 0 and count = 0. Sticky flags are unaffected. push and pop are ignored.
- stall = 1 (no flush): no state change. No flag is set even if push or pop is requested.
- clr_err = 1: clears both flags. An error event in the same cycle wins, so the flag stays 1.
- push only, not full: mem[sp] = push_data, sp++, count++.
- push only, full, OVERWRITE = 1: mem[sp] = push_data, sp++, count stays DEPTH (oldest entry lost). Set overflow.
- push only, full, OVERWRITE = 0: no state change. Set overflow.
- pop only, not empty: sp--, count--. The popped value is the top seen during that cycle.
- pop only, empty: no change. Set underflow.
- push and pop together, not empty: replace top (mem[sp-1] = push_data). sp and count are unchanged; no flag is set even if full.
- push and pop together, empty: behaves as a push only. No underflow.
- Wrap-around: sp goes DEPTH-1 to 0 on push and 0 to DEPTH-1 on pop. Contents remain correct for up to DEPTH live entries.

Test Plan:
- Reset, then push 0x0010, 0x0020, 0x0030 -> count = 3, top = 0x0030. Then pop twice -> top = 0x0010, count = 1, no flags set.
- DEPTH = 8, OVERWRITE = 1: push 0x0001..0x0009 -> full = 1, overflow = 1, count = 8, top = 0x0009. Then 8 pops return 0x0009 down to 0x0002 and empty = 1.
- OVERWRITE = 0, stack full with top 0x0008: push 0x00AA -> top stays 0x0008, overflow = 1. Then clr_err -> overflow = 0.
- Empty stack: pop -> underflow = 1, top = 0. Then simultaneous push 0x1234 and pop -> count = 1, top = 0x1234.
- Two entries, top 0x0020: simultaneous push 0x0055 and pop -> count = 2, top = 0x0055. The same request with stall = 1 -> no change.
- Three entries: push with flush = 1 -> count = 0, top = 0, flags retained. Assert rst asynchronously mid-push -> outputs go to zero before the next edge.

Source files
------------

// File: rtl/return_addr_stack.sv
// DEPTH-entry LIFO of return addresses beside the PC fetch logic; top/status are decoded straight from registers.
// A push or pop lands on the next rising edge; stall freezes state, flush empties the stack, no backpressure.
module return_addr_stack #(
   parameter int DATA_W    = 16,
   parameter int DEPTH     = 8,
   parameter int OVERWRITE = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [DATA_W-1:0]          push_data,
   input  logic                       stall,
   input  logic                       flush,
   input  logic                       clr_err,
   output logic [DATA_W-1:0]          top,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  sp;
   logic [PTR_W-1:0]  sp_dec;
   logic [PTR_W-1:0]  sp_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [PTR_W-1:0]  wr_addr;
   logic              active;
   logic              replace;
   logic              push_eff;
   logic              pop_eff;
   logic              wr_en;
   logic              ovf_evt;
   logic              unf_evt;

   assign sp_dec = sp - PTR_W'(1);
   assign empty  = (cnt == '0);
   assign full   = (cnt == CNT_FULL);
   assign count  = cnt;
   // Memory is never reset, so stale contents must be masked while empty.
   assign top    = empty ? '0 : mem[sp_dec];

   always_comb begin
      active   = !flush && !stall;
      replace  = active && push && pop && !empty;
      push_eff = active && push && !replace;
      pop_eff  = active && pop && !push;
      ovf_evt  = push_eff && full;
      unf_evt  = pop_eff && empty;
      wr_en    = replace || (push_eff && (!full || (OVERWRITE != 0)));
      wr_addr  = replace ? sp_dec : sp;

      sp_nxt  = sp;
      cnt_nxt = cnt;
      if (flush) begin
         sp_nxt  = '0;
         cnt_nxt = '0;
      end else if (push_eff && !full) begin
         sp_nxt  = sp + PTR_W'(1);
         cnt_nxt = cnt + CNT_W'(1);
      end else if (push_eff && (OVERWRITE != 0)) begin
         // Full and overwriting: the pointer wraps onto the oldest slot, count saturates.
         sp_nxt  = sp + PTR_W'(1);
      end else if (pop_eff && !empty) begin
         sp_nxt  = sp_dec;
         cnt_nxt = cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp        <= '0;
         cnt       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         sp        <= sp_nxt;
         cnt       <= cnt_nxt;
         // A fresh error event outranks a same-cycle clear.
         overflow  <= ovf_evt | (overflow & ~clr_err);
         underflow <= unf_evt | (underflow & ~clr_err);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= push_data;
      end
   end

endmodule
